muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M multiply/divide engine alongside the EX-stage ALU.
- Accepts an M-extension op from EX, holds EX via a stall to the hazard unit, and iterates 32 cycles (shift-add multiply, restoring divide).
- Presents the 32-bit result for one cycle so it is muxed into ALUResultE before the ID/EX-to-EX/MEM handoff.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- MulDivE  input  1  EX instruction is an M-extension op (funct7=0000001, OP opcode)
- Funct3E  input  3  M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  input  XLEN  forwarded rs1 operand
- SrcBE  input  XLEN  forwarded rs2 operand
- FlushE  input  1  hazard-unit flush of EX stage
- StallMD  output  1  to hazard unit: freeze PC/IF/ID/ID-EX while high
- MDDoneE  output  1  result valid this cycle
- MDResultE  output  XLEN  M-op result, valid only when MDDoneE=1

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - state=IDLE, counter=0, all datapath registers 0.
  - StallMD=0, MDDoneE=0, MDResultE=0.
  - Reset mid-operation aborts with no result.
- States: IDLE, CALC, DONE.
- IDLE:
  - StallMD = MulDivE & ~FlushE, combinationally.
  - On MulDivE=1 and FlushE=0 (accept cycle T): latch Funct3E, SrcAE, SrcBE, and sign flags.
  - Signed ops (MULH a,b; MULHSU a only; DIV/REM both) convert negative operands to magnitude.
  - Next state: CALC with counter=0, or DONE directly if a special case applies.
- Special cases, decided at accept:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Special case result at T+1: DONE, StallMD=0, MDDoneE=1.
- CALC:
  - One iteration per cycle, counter 0..XLEN-1; StallMD=1.
  - Multiply: 64-bit unsigned shift-add accumulator.
  - Divide: restoring, 32-bit remainder, quotient shifted in LSB first.
  - After counter=XLEN-1, go to DONE.
  - Normal op: CALC occupies T+1..T+32; DONE at T+33.
- DONE (one cycle):
  - StallMD=0, MDDoneE=1; MDResultE driven from a registered final value with sign fixup applied.
  - MUL → low 32 bits of the product.
  - MULH/MULHSU/MULHU → high 32 bits of the product, negated as 64-bit if result sign=1.
  - DIV quotient negated if operand signs differ; REM remainder takes the dividend's sign.
  - Next state IDLE unconditionally. MulDivE still high in DONE never retriggers, since the instruction leaves EX at this edge.
  - Back-to-back M ops are accepted starting the cycle after DONE.
- Total stall for a normal op: 33 cycles (T..T+32); the result is consumed at T+33.
- FlushE=1 in CALC or DONE: StallMD=0 and MDDoneE=0 combinationally; next state IDLE; result discarded.
- FlushE=1 in IDLE blocks acceptance.
- Outside DONE, MDResultE holds its last registered value. Consumers qualify it with MDDoneE.
- Operands are never re-sampled after accept, so forwarding changes during the stall have no effect.

Test Plan:
- Reset then MUL SrcAE=7, SrcBE=0xFFFFFFFD → StallMD high 33 cycles; MDDoneE=1 at T+33; MDResultE=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. All three: MDDoneE at T+1, stall 1 cycle.
- Start DIV, assert FlushE at T+10 → StallMD=0 that cycle, no MDDoneE, IDLE at T+11. Repeat with rst at T+10 → outputs 0 at T+11.
- Back-to-back MUL then DIVU with MulDivE held high → second accept the cycle after first MDDoneE; exactly one MDDoneE pulse per op.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiply and restoring divide, one iteration per cycle, with result fixup on completion.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MulDivE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            MDDoneE,
  output logic [XLEN-1:0] MDResultE
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] div_sel;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    result_d = result_q;
    StallMD  = 1'b0;
    MDDoneE  = 1'b0;
    a_neg    = 1'b0;
    b_neg    = 1'b0;
    a_mag    = SrcAE;
    b_mag    = SrcBE;
    addend   = '0;
    sum      = '0;
    trial    = '0;
    prod_fix = '0;
    div_sel  = '0;

    unique case (state_q)
      IDLE: begin
        StallMD = MulDivE & ~FlushE;
        if (MulDivE && !FlushE) begin
          f3_d  = Funct3E;
          cnt_d = '0;
          // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
          a_neg = SrcAE[XLEN-1] & (Funct3E == 3'b001 || Funct3E == 3'b010 ||
                                   Funct3E == 3'b100 || Funct3E == 3'b110);
          b_neg = SrcBE[XLEN-1] & (Funct3E == 3'b001 || Funct3E == 3'b100 ||
                                   Funct3E == 3'b110);
          a_mag = a_neg ? (~SrcAE + 1'b1) : SrcAE;
          b_mag = b_neg ? (~SrcBE + 1'b1) : SrcBE;
          hi_d  = '0;
          if (Funct3E[2]) begin
            neg_d  = Funct3E[1] ? a_neg : (a_neg ^ b_neg);
            opnd_d = b_mag;
            lo_d   = a_mag;
          end else begin
            neg_d  = a_neg ^ b_neg;
            opnd_d = a_mag;
            lo_d   = b_mag;
          end
          if (Funct3E[2] && SrcBE == '0) begin
            state_d  = DONE;
            result_d = Funct3E[1] ? SrcAE : '1;
          end else if (!Funct3E[0] && Funct3E[2] && SrcAE == MIN_INT && SrcBE == '1) begin
            state_d  = DONE;
            result_d = Funct3E[1] ? '0 : MIN_INT;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (FlushE) begin
          state_d = IDLE;
        end else begin
          StallMD = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (!f3_q[2]) begin
            addend = lo_q[0] ? opnd_q : '0;
            sum    = {1'b0, hi_q} + {1'b0, addend};
            hi_d   = sum[XLEN:1];
            lo_d   = {sum[0], lo_q[XLEN-1:1]};
          end else begin
            // hi holds the partial remainder, lo shifts dividend bits out and quotient bits in
            trial = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};
            if (!trial[XLEN]) begin
              hi_d = trial[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end
          if (cnt_q == CW'(XLEN-1)) begin
            state_d = DONE;
            if (!f3_q[2]) begin
              prod_fix = neg_q ? (~{hi_d, lo_d} + 1'b1) : {hi_d, lo_d};
              result_d = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            end else begin
              div_sel  = f3_q[1] ? hi_d : lo_d;
              result_d = neg_q ? (~div_sel + 1'b1) : div_sel;
            end
          end
        end
      end

      DONE: begin
        MDDoneE = ~FlushE;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign MDResultE = result_q;

endmodule
